// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: datapath defaults and ALU operation encodings.
package id_ex_stage_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int REG_AW_DEF = 5;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SLL  = 4'b0001,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111,
      ALU_SUB  = 4'b1000,
      ALU_SRA  = 4'b1101
   } alu_op_e;

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass: selects the youngest in-flight producer of a source register,
// falling back to the register-file value captured at decode.
module fwd_mux
   import id_ex_stage_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic [REG_AW-1:0] rs_addr,
   input  logic [XLEN-1:0]   rs_data,
   input  logic [REG_AW-1:0] mem_rd_addr,
   input  logic              mem_reg_write,
   input  logic [XLEN-1:0]   mem_result,
   input  logic [REG_AW-1:0] wb_rd_addr,
   input  logic              wb_reg_write,
   input  logic [XLEN-1:0]   wb_result,
   output logic [XLEN-1:0]   fwd_data
);

   logic mem_hit;
   logic wb_hit;

   // x0 is hardwired to zero, so a write "to" it must never be bypassed.
   assign mem_hit = mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == rs_addr);
   assign wb_hit  = wb_reg_write  && (wb_rd_addr  != '0) && (wb_rd_addr  == rs_addr);

   always_comb begin
      fwd_data = rs_data;
      if (mem_hit) begin
         fwd_data = mem_result;
      end else if (wb_hit) begin
         fwd_data = wb_result;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush, and MEM/WB operand forwarding
// feeding the ALU operands directly.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [XLEN-1:0]   id_rs1_data,
   input  logic [XLEN-1:0]   id_rs2_data,
   input  logic [REG_AW-1:0] id_rs1_addr,
   input  logic [REG_AW-1:0] id_rs2_addr,
   input  logic [REG_AW-1:0] id_rd_addr,
   input  logic              id_uses_rs1,
   input  logic              id_uses_rs2,
   input  logic [XLEN-1:0]   id_imm,
   input  logic              id_src_a_pc,
   input  logic              id_src_b_imm,
   input  logic [3:0]        id_alu_control,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_branch,
   input  logic [REG_AW-1:0] mem_rd_addr,
   input  logic              mem_reg_write,
   input  logic [XLEN-1:0]   mem_result,
   input  logic [REG_AW-1:0] wb_rd_addr,
   input  logic              wb_reg_write,
   input  logic [XLEN-1:0]   wb_result,
   input  logic              ex_ready,
   output logic              ex_valid,
   output logic [XLEN-1:0]   SrcA,
   output logic [XLEN-1:0]   SrcB,
   output logic [3:0]        ALUControl,
   output logic [XLEN-1:0]   ex_store_data,
   output logic [XLEN-1:0]   ex_pc,
   output logic [REG_AW-1:0] ex_rd_addr,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_branch
);

   logic              free;
   logic              load_use;
   logic [XLEN-1:0]   rs1_data_p1;
   logic [XLEN-1:0]   rs2_data_p1;
   logic [REG_AW-1:0] rs1_addr_p1;
   logic [REG_AW-1:0] rs2_addr_p1;
   logic [XLEN-1:0]   imm_p1;
   logic              src_a_pc_p1;
   logic              src_b_imm_p1;
   logic [XLEN-1:0]   fwd_a;
   logic [XLEN-1:0]   fwd_b;

   assign free = !ex_valid || ex_ready;

   // A load's data is not available to bypass until it reaches MEM, so a
   // dependent instruction in decode must wait one cycle behind a bubble.
   assign load_use = ex_valid && ex_mem_read && (ex_rd_addr != '0) &&
                     ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                      (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));

   assign id_ready = free && !load_use && !flush;

   // ID -> EX boundary
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid     <= 1'b0;
         ex_pc        <= '0;
         ex_rd_addr   <= '0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         ex_branch    <= 1'b0;
         ALUControl   <= ALU_ADD;
         rs1_data_p1  <= '0;
         rs2_data_p1  <= '0;
         rs1_addr_p1  <= '0;
         rs2_addr_p1  <= '0;
         imm_p1       <= '0;
         src_a_pc_p1  <= 1'b0;
         src_b_imm_p1 <= 1'b0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (free && load_use) begin
         ex_valid     <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         ex_branch    <= 1'b0;
      end else if (free && id_valid) begin
         ex_valid     <= 1'b1;
         ex_pc        <= id_pc;
         ex_rd_addr   <= id_rd_addr;
         ex_reg_write <= id_reg_write && (id_rd_addr != '0);
         ex_mem_read  <= id_mem_read;
         ex_mem_write <= id_mem_write;
         ex_branch    <= id_branch;
         ALUControl   <= id_alu_control;
         rs1_data_p1  <= id_rs1_data;
         rs2_data_p1  <= id_rs2_data;
         rs1_addr_p1  <= id_rs1_addr;
         rs2_addr_p1  <= id_rs2_addr;
         imm_p1       <= id_imm;
         src_a_pc_p1  <= id_src_a_pc;
         src_b_imm_p1 <= id_src_b_imm;
      end else if (free) begin
         ex_valid <= 1'b0;
      end
   end

   // EX operand selection, live every cycle so held instructions see new producers
   fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
      .rs_addr       (rs1_addr_p1),
      .rs_data       (rs1_data_p1),
      .mem_rd_addr   (mem_rd_addr),
      .mem_reg_write (mem_reg_write),
      .mem_result    (mem_result),
      .wb_rd_addr    (wb_rd_addr),
      .wb_reg_write  (wb_reg_write),
      .wb_result     (wb_result),
      .fwd_data      (fwd_a)
   );

   fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
      .rs_addr       (rs2_addr_p1),
      .rs_data       (rs2_data_p1),
      .mem_rd_addr   (mem_rd_addr),
      .mem_reg_write (mem_reg_write),
      .mem_result    (mem_result),
      .wb_rd_addr    (wb_rd_addr),
      .wb_reg_write  (wb_reg_write),
      .wb_result     (wb_result),
      .fwd_data      (fwd_b)
   );

   assign SrcA          = src_a_pc_p1  ? ex_pc  : fwd_a;
   assign SrcB          = src_b_imm_p1 ? imm_p1 : fwd_b;
   assign ex_store_data = fwd_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expectations are queued as instructions are
// offered to decode and retired against the EX outputs one edge later.
module tb_id_ex_stage;
   import id_ex_stage_pkg::*;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              flush;
   logic              id_valid;
   logic              id_ready;
   logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [REG_AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic              id_uses_rs1, id_uses_rs2, id_src_a_pc, id_src_b_imm;
   logic [3:0]        id_alu_control;
   logic              id_reg_write, id_mem_read, id_mem_write, id_branch;
   logic [REG_AW-1:0] mem_rd_addr, wb_rd_addr;
   logic              mem_reg_write, wb_reg_write;
   logic [XLEN-1:0]   mem_result, wb_result;
   logic              ex_ready;
   logic              ex_valid;
   logic [XLEN-1:0]   SrcA, SrcB, ex_store_data, ex_pc;
   logic [3:0]        ALUControl;
   logic [REG_AW-1:0] ex_rd_addr;
   logic              ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] st;
      logic [3:0]  alu;
      logic [4:0]  rd;
      logic        rw;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   exp_t obs;
   int   checks = 0;
   int   errors = 0;

   assign obs = {SrcA, SrcB, ex_store_data, ALUControl, ex_rd_addr, ex_reg_write};

   id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_imm(id_imm),
      .id_src_a_pc(id_src_a_pc), .id_src_b_imm(id_src_b_imm),
      .id_alu_control(id_alu_control), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
      .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
      .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
      .ex_ready(ex_ready), .ex_valid(ex_valid), .SrcA(SrcA), .SrcB(SrcB),
      .ALUControl(ALUControl), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
      .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_branch(ex_branch)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      flush = 0; id_valid = 0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0;
      id_imm = '0; id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
      id_uses_rs1 = 0; id_uses_rs2 = 0; id_src_a_pc = 0; id_src_b_imm = 0;
      id_alu_control = ALU_ADD; id_reg_write = 0; id_mem_read = 0;
      id_mem_write = 0; id_branch = 0; mem_rd_addr = '0; mem_reg_write = 0;
      mem_result = '0; wb_rd_addr = '0; wb_reg_write = 0; wb_result = '0;
      ex_ready = 1;
   endtask

   task automatic set_instr(input logic [31:0] pc, input logic [31:0] r1d,
                            input logic [31:0] r2d, input logic [31:0] imm,
                            input logic [4:0] r1, input logic [4:0] r2,
                            input logic [4:0] rd, input logic [3:0] alu,
                            input logic rw, input logic mr,
                            input logic sa, input logic sbi);
      id_valid = 1; id_pc = pc; id_rs1_data = r1d; id_rs2_data = r2d; id_imm = imm;
      id_rs1_addr = r1; id_rs2_addr = r2; id_rd_addr = rd; id_alu_control = alu;
      id_uses_rs1 = 1; id_uses_rs2 = 1; id_reg_write = rw; id_mem_read = mr;
      id_mem_write = 0; id_branch = 0; id_src_a_pc = sa; id_src_b_imm = sbi;
   endtask

   task automatic test_reset;
      idle_inputs();
      set_instr(32'h0, 32'h11, 32'h22, 32'h0, 5'd1, 5'd2, 5'd3, ALU_AND, 1, 0, 0, 0);
      sb.push_back('{32'h11, 32'h22, 32'h22, ALU_AND, 5'd3, 1'b1});
      tick();
      if (sb.size() == 0) begin checks++; errors++; $display("FAIL rst_pre: scoreboard empty"); end
      else begin
         e = sb.pop_front(); checks++;
         if (!ex_valid || obs !== e) begin errors++; $display("FAIL rst_pre: got v=%b %h need %h", ex_valid, obs, e); end
      end
      // assert reset asynchronously while another instruction is being offered
      ex_ready = 0;
      #2 reset = 1;
      #1;
      checks++;
      if ({ex_valid, ex_reg_write, ALUControl, SrcA, SrcB, ex_store_data} !== '0) begin
         errors++;
         $display("FAIL rst_state: got v=%b rw=%b alu=%h a=%h b=%h st=%h need all zero",
                  ex_valid, ex_reg_write, ALUControl, SrcA, SrcB, ex_store_data);
      end
      tick();
      reset = 0; ex_ready = 1; idle_inputs();
      set_instr(32'h0, 32'd5, 32'd7, 32'h0, 5'd1, 5'd2, 5'd4, ALU_ADD, 1, 0, 0, 0);
      #1;
      checks++;
      if (id_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b need 1", id_ready); end
      sb.push_back('{32'd5, 32'd7, 32'd7, ALU_ADD, 5'd4, 1'b1});
      tick();
      id_valid = 0;
      if (sb.size() == 0) begin checks++; errors++; $display("FAIL rst_first: scoreboard empty"); end
      else begin
         e = sb.pop_front(); checks++;
         if (!ex_valid || obs !== e) begin errors++; $display("FAIL rst_first: got v=%b %h need %h", ex_valid, obs, e); end
      end
      tick();
   endtask

   task automatic test_forwarding;
      idle_inputs();
      mem_rd_addr = 5'd3; mem_reg_write = 1; mem_result = 32'h10;
      wb_rd_addr  = 5'd3; wb_reg_write  = 1; wb_result  = 32'h20;
      set_instr(32'h0, 32'h1, 32'h9, 32'h0, 5'd3, 5'd4, 5'd7, ALU_ADD, 1, 0, 0, 0);
      sb.push_back('{32'h10, 32'h9, 32'h9, ALU_ADD, 5'd7, 1'b1});
      tick();
      id_valid = 0; ex_ready = 0;
      if (sb.size() == 0) begin checks++; errors++; $display("FAIL fwd_mem_prio: scoreboard empty"); end
      else begin
         e = sb.pop_front(); checks++;
         if (!ex_valid || obs !== e) begin errors++; $display("FAIL fwd_mem_prio: got v=%b %h need %h", ex_valid, obs, e); end
      end
      mem_reg_write = 0;
      #1;
      checks++;
      if (SrcA !== 32'h20) begin errors++; $display("FAIL fwd_wb: got %h need 00000020", SrcA); end
      wb_reg_write = 0;
      #1;
      checks++;
      if (SrcA !== 32'h1) begin errors++; $display("FAIL fwd_none: got %h need 00000001", SrcA); end
      ex_ready = 1;
      tick();
      mem_rd_addr = 5'd0; mem_reg_write = 1; mem_result = 32'h55;
      wb_rd_addr  = 5'd0; wb_reg_write  = 1; wb_result  = 32'h66;
      set_instr(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, ALU_ADD, 1, 0, 0, 0);
      sb.push_back('{32'h0, 32'h0, 32'h0, ALU_ADD, 5'd0, 1'b0});
      tick();
      id_valid = 0;
      if (sb.size() == 0) begin checks++; errors++; $display("FAIL fwd_x0: scoreboard empty"); end
      else begin
         e = sb.pop_front(); checks++;
         if (!ex_valid || obs !== e) begin errors++; $display("FAIL fwd_x0: got v=%b %h need %h", ex_valid, obs, e); end
      end
      tick();
   endtask

   task automatic test_load_use;
      idle_inputs();
      set_instr(32'h0, 32'h100, 32'h0, 32'h4, 5'd2, 5'd0, 5'd5, ALU_ADD, 1, 1, 0, 1);
      #1;
      checks++;
      if (id_ready !== 1'b1) begin errors++; $display("FAIL lu_load_ready: got %b need 1", id_ready); end
      sb.push_back('{32'h100, 32'h4, 32'h0, ALU_ADD, 5'd5, 1'b1});
      tick();
      if (sb.size() == 0) begin checks++; errors++; $display("FAIL lu_load: scoreboard empty"); end
      else begin
         e = sb.pop_front(); checks++;
         if (!ex_valid || !ex_mem_read || obs !== e) begin errors++; $display("FAIL lu_load: got v=%b mr=%b %h need %h", ex_valid, ex_mem_read, obs, e); end
      end
      set_instr(32'h0, 32'hDEAD, 32'h3, 32'h0, 5'd5, 5'd1, 5'd6, ALU_ADD, 1, 0, 0, 0);
      #1;
      checks++;
      if (id_ready !== 1'b0) begin errors++; $display("FAIL lu_stall: got %b need 0", id_ready); end
      tick();
      checks++;
      if ({ex_valid, ex_reg_write, ex_mem_read} !== 3'b000) begin
         errors++; $display("FAIL lu_bubble: got v/rw/mr=%b%b%b need 000", ex_valid, ex_reg_write, ex_mem_read);
      end
      // the load has advanced to MEM and is now a bypass source
      mem_rd_addr = 5'd5; mem_reg_write = 1; mem_result = 32'h77;
      #1;
      checks++;
      if (id_ready !== 1'b1) begin errors++; $display("FAIL lu_release: got %b need 1", id_ready); end
      sb.push_back('{32'h77, 32'h3, 32'h3, ALU_ADD, 5'd6, 1'b1});
      tick();
      id_valid = 0;
      if (sb.size() == 0) begin checks++; errors++; $display("FAIL lu_fwd: scoreboard empty"); end
      else begin
         e = sb.pop_front(); checks++;
         if (!ex_valid || obs !== e) begin errors++; $display("FAIL lu_fwd: got v=%b %h need %h", ex_valid, obs, e); end
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_stall;
      idle_inputs();
      wb_rd_addr = 5'd9; wb_reg_write = 1; wb_result = 32'h1;
      set_instr(32'h0, 32'h11, 32'hAA, 32'h0, 5'd8, 5'd9, 5'd10, ALU_SUB, 1, 0, 0, 0);
      sb.push_back('{32'h11, 32'h1, 32'h1, ALU_SUB, 5'd10, 1'b1});
      tick();
      if (sb.size() == 0) begin checks++; errors++; $display("FAIL st_enter: scoreboard empty"); end
      else begin
         e = sb.pop_front(); checks++;
         if (!ex_valid || obs !== e) begin errors++; $display("FAIL st_enter: got v=%b %h need %h", ex_valid, obs, e); end
      end
      ex_ready = 0;
      set_instr(32'h0, 32'h1234, 32'h5, 32'h0, 5'd12, 5'd13, 5'd11, ALU_XOR, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         if (i == 1) wb_result = 32'h2;
         #1;
         e = '{32'h11, (i == 0) ? 32'h1 : 32'h2, (i == 0) ? 32'h1 : 32'h2, ALU_SUB, 5'd10, 1'b1};
         checks++;
         if (id_ready !== 1'b0 || !ex_valid || obs !== e) begin
            errors++; $display("FAIL st_hold%0d: got rdy=%b v=%b %h need rdy=0 v=1 %h", i, id_ready, ex_valid, obs, e);
         end
         tick();
      end
      ex_ready = 1; wb_reg_write = 0;
      #1;
      checks++;
      if (id_ready !== 1'b1) begin errors++; $display("FAIL st_release: got %b need 1", id_ready); end
      sb.push_back('{32'h1234, 32'h5, 32'h5, ALU_XOR, 5'd11, 1'b1});
      tick();
      id_valid = 0;
      if (sb.size() == 0) begin checks++; errors++; $display("FAIL st_next: scoreboard empty"); end
      else begin
         e = sb.pop_front(); checks++;
         if (!ex_valid || obs !== e) begin errors++; $display("FAIL st_next: got v=%b %h need %h", ex_valid, obs, e); end
      end
      tick();
   endtask

   task automatic test_flush;
      idle_inputs();
      set_instr(32'h0, 32'h40, 32'h0, 32'h8, 5'd2, 5'd0, 5'd5, ALU_ADD, 1, 1, 0, 1);
      sb.push_back('{32'h40, 32'h8, 32'h0, ALU_ADD, 5'd5, 1'b1});
      tick();
      if (sb.size() == 0) begin checks++; errors++; $display("FAIL fl_load: scoreboard empty"); end
      else begin
         e = sb.pop_front(); checks++;
         if (!ex_valid || obs !== e) begin errors++; $display("FAIL fl_load: got v=%b %h need %h", ex_valid, obs, e); end
      end
      set_instr(32'h0, 32'h9, 32'h0, 32'h0, 5'd5, 5'd0, 5'd6, ALU_ADD, 1, 0, 0, 0);
      flush = 1;
      #1;
      checks++;
      if (id_ready !== 1'b0) begin errors++; $display("FAIL fl_ready: got %b need 0", id_ready); end
      tick();
      flush = 0;
      checks++;
      if (ex_valid !== 1'b0 || ex_mem_read !== 1'b1 || ex_rd_addr !== 5'd5) begin
         errors++; $display("FAIL fl_kill: got v=%b mr=%b rd=%0d need v=0 mr=1 rd=5", ex_valid, ex_mem_read, ex_rd_addr);
      end
      #1;
      checks++;
      if (id_ready !== 1'b1) begin errors++; $display("FAIL fl_no_stall: got %b need 1", id_ready); end
      sb.push_back('{32'h9, 32'h0, 32'h0, ALU_ADD, 5'd6, 1'b1});
      tick();
      id_valid = 0;
      if (sb.size() == 0) begin checks++; errors++; $display("FAIL fl_after: scoreboard empty"); end
      else begin
         e = sb.pop_front(); checks++;
         if (!ex_valid || obs !== e) begin errors++; $display("FAIL fl_after: got v=%b %h need %h", ex_valid, obs, e); end
      end
      set_instr(32'h0, 32'h3, 32'h4, 32'h0, 5'd1, 5'd2, 5'd7, ALU_OR, 1, 0, 0, 0);
      sb.push_back('{32'h3, 32'h4, 32'h4, ALU_OR, 5'd7, 1'b1});
      tick();
      if (sb.size() == 0) begin checks++; errors++; $display("FAIL fl_stall_enter: scoreboard empty"); end
      else begin
         e = sb.pop_front(); checks++;
         if (!ex_valid || obs !== e) begin errors++; $display("FAIL fl_stall_enter: got v=%b %h need %h", ex_valid, obs, e); end
      end
      ex_ready = 0;
      tick();
      flush = 1;
      tick();
      flush = 0; id_valid = 0;
      checks++;
      if (ex_valid !== 1'b0) begin errors++; $display("FAIL fl_stall_kill: got %b need 0", ex_valid); end
      ex_ready = 1;
      tick();
   endtask

   task automatic test_src_sel;
      idle_inputs();
      mem_rd_addr = 5'd4; mem_reg_write = 1; mem_result = 32'h99;
      set_instr(32'h100, 32'h1, 32'h33, 32'hFFFFFFFC, 5'd1, 5'd4, 5'd8, ALU_ADD, 1, 0, 1, 1);
      sb.push_back('{32'h100, 32'hFFFFFFFC, 32'h99, ALU_ADD, 5'd8, 1'b1});
      tick();
      id_valid = 0;
      if (sb.size() == 0) begin checks++; errors++; $display("FAIL src_sel: scoreboard empty"); end
      else begin
         e = sb.pop_front(); checks++;
         if (!ex_valid || obs !== e) begin errors++; $display("FAIL src_sel: got v=%b %h need %h", ex_valid, obs, e); end
      end
      checks++;
      if (ex_pc !== 32'h100) begin errors++; $display("FAIL src_pc: got %h need 00000100", ex_pc); end
      tick();
   endtask

   task automatic test_back_to_back;
      logic [3:0]  ops [10];
      logic [31:0] r1d, r2d;
      logic [4:0]  rd, r1, r2;
      ops = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND};
      idle_inputs();
      for (int k = 0; k < 10; k++) begin
         r1d = $urandom; r2d = $urandom;
         rd = 5'($urandom_range(1, 31)); r1 = 5'($urandom_range(1, 31)); r2 = 5'($urandom_range(1, 31));
         set_instr(32'h0, r1d, r2d, 32'h0, r1, r2, rd, ops[k], 1, 0, 0, 0);
         #1;
         checks++;
         if (id_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b need 1", k, id_ready); end
         sb.push_back('{r1d, r2d, r2d, ops[k], rd, 1'b1});
         tick();
         if (sb.size() == 0) begin checks++; errors++; $display("FAIL b2b%0d: scoreboard empty", k); end
         else begin
            e = sb.pop_front(); checks++;
            if (!ex_valid || obs !== e) begin errors++; $display("FAIL b2b%0d: got v=%b %h need %h", k, ex_valid, obs, e); end
         end
      end
      id_valid = 0;
      tick();
   endtask

   initial begin
      idle_inputs();
      reset = 1;
      tick();
      tick();
      reset = 0;
      test_reset();
      test_forwarding();
      test_load_use();
      test_stall();
      test_flush();
      test_src_sel();
      test_back_to_back();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d entries need 0", sb.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-selection stage directly upstream of the ALU.
- Registers decoded instruction fields on a valid/ready handshake.
- Resolves RAW hazards by forwarding from the MEM and WB stages, and detects load-use hazards, stalling decode and inserting a bubble.
- Drives SrcA, SrcB and ALUControl straight into the ALU, plus control sideband for downstream stages.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset, asynchronous, active-high
flush  in  1  sync kill of EX slot (branch taken / trap)
id_valid  in  1  decode presents an instruction
id_ready  out  1  stage accepts the decode instruction this cycle
id_pc  in  XLEN  instruction PC
id_rs1_data, id_rs2_data  in  XLEN  register file read data
id_rs1_addr, id_rs2_addr, id_rd_addr  in  REG_AW  register indices
id_uses_rs1, id_uses_rs2  in  1  instruction actually reads rs1 / rs2
id_imm  in  XLEN  sign-extended immediate
id_src_a_pc  in  1  SrcA = PC (AUIPC/JAL)
id_src_b_imm  in  1  SrcB = immediate
id_alu_control  in  4  ALU operation code
id_reg_write, id_mem_read, id_mem_write, id_branch  in  1  control bits
mem_rd_addr  in  REG_AW  MEM-stage destination register
mem_reg_write  in  1  MEM-stage write enable
mem_result  in  XLEN  MEM-stage result
wb_rd_addr  in  REG_AW  WB-stage destination register
wb_reg_write  in  1  WB-stage write enable
wb_result  in  XLEN  WB-stage result
ex_ready  in  1  downstream accepts the EX slot
ex_valid  out  1  EX slot holds a live instruction
SrcA, SrcB  out  XLEN  ALU operands
ALUControl  out  4  ALU operation code
ex_store_data  out  XLEN  forwarded rs2 value for stores
ex_pc  out  XLEN  registered PC
ex_rd_addr  out  REG_AW  registered destination register
ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  out  1  registered control bits

Behaviour:
- Reset (async): all registers 0; ex_valid=0, ALUControl=ADD (0000). SrcA, SrcB and ex_store_data read 0.
- Latency: 1 cycle. Instruction accepted on edge N appears at the EX outputs after edge N.
- Transfer occurs when id_valid && id_ready.
- free = !ex_valid || ex_ready.
- load_use: ex_valid && ex_mem_read && ex_rd_addr!=0 && ((id_uses_rs1 && id_rs1_addr==ex_rd_addr) || (id_uses_rs2 && id_rs2_addr==ex_rd_addr)).
- id_ready = free && !load_use && !flush. Combinational, no dependency on id_valid.
- Next-state priority per edge:
  1. flush: ex_valid<=0, fields unchanged.
  2. free && load_use: bubble, ex_valid<=0, ex_reg_write/ex_mem_read/ex_mem_write/ex_branch<=0.
  3. free && id_valid: load all fields, ex_valid<=1.
  4. free && !id_valid: ex_valid<=0.
  5. otherwise (ex_valid && !ex_ready): hold everything.
- Registered ex_reg_write = id_reg_write && id_rd_addr!=0. x0 writes are dropped at entry.
- Forwarding is combinational on registered rs addr/data, re-evaluated every cycle including held cycles. For each operand:
  - if mem_reg_write && mem_rd_addr!=0 && mem_rd_addr==rs: use mem_result;
  - else if wb_reg_write && wb_rd_addr!=0 && wb_rd_addr==rs: use wb_result;
  - else use the registered rs data.
  - MEM has priority over WB. x0 is never forwarded.
- SrcA = ex_src_a_pc ? ex_pc : fwdA.
- SrcB = ex_src_b_imm ? ex_imm : fwdB.
- ex_store_data = fwdB, always, independent of src_b_imm.
- ALUControl is passed through unmodified. Encodings: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- Datapath outputs are don't-care while ex_valid=0, but must be X-free.
- Flush during a downstream stall kills the held instruction.
- Flush coincident with load_use: flush wins and no stall is generated.
- Reset mid-stall: returns immediately to the empty state, with no partial load.

Decomposition:
- Shared header riscv_defs.vh: ALU op codes (ADD..AND), XLEN, REG_AW.
- One sub-module, fwd_mux: rs addr/data plus MEM/WB ports in, forwarded value out. Instantiated twice, for rs1 and rs2.
- Hazard detection and the pipeline register stay inline.

Test Plan:
- Reset asserted mid-transfer, then released -> ex_valid=0, ALUControl=0000, SrcA=SrcB=0. The next id_valid with rs1_data=5, rs2_data=7, ADD appears after 1 edge with SrcA=5, SrcB=7.
- EX instr rs1=x3 (stale 1); mem_rd=x3 result 0x10 and wb_rd=x3 result 0x20, both writing -> SrcA=0x10. Drop mem_reg_write -> SrcA=0x20. rs1=x0 with mem_rd=x0 writing -> SrcA=0.
- Load `lw x5` in EX; decode `add x6,x5,x1` valid -> id_ready=0 for exactly 1 cycle, bubble (ex_valid=0, ex_reg_write=0). The add then enters and reads the MEM-forwarded value.
- ex_ready=0 for 3 cycles with a valid EX slot -> id_ready=0 and outputs held. wb_result changing from 0x1 to 0x2 on the matching rs is reflected live in SrcB.
- flush asserted together with id_valid and load_use -> next cycle ex_valid=0; id_ready=0 during the flush cycle, and no stall on the following cycle.
- id_src_a_pc=1, id_pc=0x100, id_src_b_imm=1, imm=0xFFFFFFFC -> SrcA=0x100, SrcB=0xFFFFFFFC, ex_store_data equals forwarded rs2.
